// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory-side blocks.
package segre_pkg;

    localparam int DCACHE_LANE_SIZE      = 128;
    localparam int ADDR_SIZE             = 32;
    localparam int MEM_ARB_PORTS_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        RESP
    } mem_arb_state_e;

endpackage

// File: rtl/segre_rr_arbiter.sv
// Winner select over N request lines: round-robin from a registered pointer,
// or fixed priority with port 0 highest.
module segre_rr_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int PRIO_MODE = 0,
    localparam int IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               rsn,
    input  logic [N_PORTS-1:0] req,
    input  logic               advance,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   base;
    logic [IDX_W:0]   k;

    // Scan from highest offset down so the port closest to the start wins.
    always_comb begin
        base      = (PRIO_MODE == 1) ? '0 : {1'b0, ptr};
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            k = base + (IDX_W + 1)'(i);
            if (k >= (IDX_W + 1)'(N_PORTS)) begin
                k = k - (IDX_W + 1)'(N_PORTS);
            end
            if (req[k[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = k[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gnt_idx == IDX_W'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Main-memory arbiter for N cache clients: optional dirty writeback, lane fill,
// then a one-cycle response to the granted client.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner and its addresses/data on grant
//   WB    | write dirty lane to memory until acknowledged
//   FILL  | read lane from memory until acknowledged
//   RESP  | pulse rsp_valid_o for the winner with the filled lane
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int N_PORTS   = MEM_ARB_PORTS_DEFAULT,
    parameter int LANE_W    = DCACHE_LANE_SIZE,
    parameter int ADDR_W    = ADDR_SIZE,
    parameter int PRIO_MODE = 0,
    localparam int IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rsn_i,
    input  logic [N_PORTS-1:0]              req_i,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]  req_addr_i,
    input  logic [N_PORTS-1:0]              wb_i,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]  wb_addr_i,
    input  logic [N_PORTS-1:0][LANE_W-1:0]  wb_data_i,
    output logic [N_PORTS-1:0]              rsp_valid_o,
    output logic [LANE_W-1:0]               rsp_data_o,
    output logic                            busy_o,
    output logic                            mm_rd_req_o,
    output logic                            mm_wr_req_o,
    output logic [ADDR_W-1:0]               mm_addr_o,
    output logic [ADDR_W-1:0]               mm_wr_addr_o,
    output logic [LANE_W-1:0]               mm_wr_data_o,
    input  logic                            mm_data_rdy_i,
    input  logic [LANE_W-1:0]               mm_rd_data_i
);

    localparam logic [ADDR_W-1:0] LANE_MASK = ~ADDR_W'((LANE_W / 8) - 1);

    mem_arb_state_e   state_q;
    logic [IDX_W-1:0] g_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [LANE_W-1:0] wb_data_q;
    logic [LANE_W-1:0] rd_data_q;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             advance;

    assign advance = (state_q == IDLE) && gnt_valid;

    segre_rr_arbiter #(
        .N_PORTS   (N_PORTS),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk       (clk_i),
        .rsn       (rsn_i),
        .req       (req_i),
        .advance   (advance),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= IDLE;
            g_q         <= '0;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        g_q         <= gnt_idx;
                        fill_addr_q <= req_addr_i[gnt_idx] & LANE_MASK;
                        wb_addr_q   <= wb_addr_i[gnt_idx] & LANE_MASK;
                        wb_data_q   <= wb_data_i[gnt_idx];
                        state_q     <= wb_i[gnt_idx] ? WB : FILL;
                    end
                end
                WB: begin
                    if (mm_data_rdy_i) state_q <= FILL;
                end
                FILL: begin
                    if (mm_data_rdy_i) begin
                        rd_data_q <= mm_rd_data_i;
                        state_q   <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and latches only; no input reaches an output.
    assign busy_o       = (state_q != IDLE);
    assign mm_wr_req_o  = (state_q == WB);
    assign mm_rd_req_o  = (state_q == FILL);
    assign mm_addr_o    = fill_addr_q;
    assign mm_wr_addr_o = wb_addr_q;
    assign mm_wr_data_o = wb_data_q;
    assign rsp_valid_o  = (state_q == RESP) ? ({{(N_PORTS-1){1'b0}}, 1'b1} << g_q) : '0;
    assign rsp_data_o   = (state_q == RESP) ? rd_data_q : '0;

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Parametrised main-memory arbiter serving N cache clients (I$, D$, and future per-core or prefetch caches) over a single main-memory port. It generalises the two-client miss path to any number of ports with a selectable priority mode. For each granted request it issues an optional dirty-lane writeback, then a lane fill, and returns the fill data to the requesting client. It sits between the cache miss logic and the main-memory interface of the core.

## Interface
- Parameters:
- N_PORTS, 2: number of cache clients, at least 2.
- LANE_W, DCACHE_LANE_SIZE: lane width in bits, a power of two and at least 32.
- ADDR_W, ADDR_SIZE: byte address width.
- PRIO_MODE, 0: 0 selects round-robin, 1 selects fixed priority (port 0 highest).
- Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- req_i  in  N_PORTS  per-port miss request, level, held until that port's rsp_valid_o
- req_addr_i  in  N_PORTS x ADDR_W  fill address per port
- wb_i  in  N_PORTS  per-port flag: a dirty writeback precedes the fill
- wb_addr_i  in  N_PORTS x ADDR_W  writeback address per port
- wb_data_i  in  N_PORTS x LANE_W  writeback lane per port
- rsp_valid_o  out  N_PORTS  one-cycle fill-complete pulse, one-hot or zero
- rsp_data_o  out  LANE_W  fill lane, broadcast, valid only with rsp_valid_o
- busy_o  out  1  high in any state other than IDLE
- mm_rd_req_o  out  1  read request to main memory
- mm_wr_req_o  out  1  write request to main memory
- mm_addr_o  out  ADDR_W  read address, lane-aligned
- mm_wr_addr_o  out  ADDR_W  write address, lane-aligned
- mm_wr_data_o  out  LANE_W  write lane
- mm_data_rdy_i  in  1  one-cycle pulse acknowledging the current read or write
- mm_rd_data_i  in  LANE_W  read lane, valid with mm_data_rdy_i

## Operation
- States: IDLE, WB, FILL, RESP.
- IDLE:
  - Arbitrates only in this state.
  - If any req_i bit is high, latches the winner index g, req_addr, wb, wb_addr and wb_data.
  - Next state is WB if wb_i[g] is high, otherwise FILL.
- WB: drives mm_wr_req_o=1 and the latched write address and data. On mm_data_rdy_i, next state is FILL.
- FILL: drives mm_rd_req_o=1 and the latched fill address. On mm_data_rdy_i, latches mm_rd_data_i and moves to RESP.
- RESP: drives rsp_valid_o[g]=1 and rsp_data_o with the latched lane, then returns to IDLE.
- Round-robin (PRIO_MODE=0):
  - Search starts at pointer ptr and wraps modulo N_PORTS; the first requesting port wins.
  - On grant, ptr becomes (g+1) mod N_PORTS; when g=N_PORTS-1, ptr wraps to 0.
  - Reset value of ptr is 0.
- Fixed priority (PRIO_MODE=1): the lowest requesting index wins and ptr is unused.
- Both mm address outputs have bits [log2(LANE_W/8)-1:0] forced to 0.
- mm_data_rdy_i is ignored in IDLE and RESP. Changes to req_i or the data inputs after grant are ignored until the next IDLE.
- Reset, including mid-operation: state goes to IDLE and the outstanding transaction is abandoned.
  - Every output is 0 and all latches are 0.
  - The memory model must tolerate a dropped request.

## Timing
- All outputs come from registers or are decoded from state; there are no combinational input-to-output paths.
- Grant is taken in IDLE cycle t; WB or FILL is entered at t+1.
- Minimum latency with no writeback and mm_data_rdy_i in the first FILL cycle: rsp_valid_o at t+2, IDLE at t+3.
- The writeback adds at least 1 cycle, plus the memory wait.
- mm_*_req_o stays high continuously until the acknowledging cycle, inclusive, and is low the cycle after.
- Clients must drop req_i by the cycle after rsp_valid_o. The earliest next grant is the IDLE cycle following RESP, so back-to-back throughput is one transaction per 3 or more cycles.

## Structure
- segre_pkg additions:
  - typedef enum mem_arb_state_e {IDLE, WB, FILL, RESP}
  - constant MEM_ARB_PORTS_DEFAULT
- Sub-module segre_rr_arbiter: combinational winner select plus the registered ptr, parametrised by N_PORTS and PRIO_MODE, with outputs gnt_valid and gnt_idx.
- Top level holds the FSM, the transaction latches and the mm and response muxing.

## Test plan
- Single read: N_PORTS=2, req_i=01, addr 0x1234, wb=0, memory ready after 3 cycles -> mm_rd_req_o high 3 cycles at mm_addr_o=0x1230 (LANE_W=128), then rsp_valid_o=01 with the memory lane.
- Writeback then fill: port 1, wb_addr 0x8000, wb_data 0xA5.., fill 0x4000 -> mm_wr_req_o until acknowledged, then mm_rd_req_o, then rsp_valid_o=10. Reads and writes never overlap.
- Round-robin fairness: N_PORTS=3, all req_i held high -> grant order 0,1,2,0,… with ptr wrapping from 2 to 0.
- Fixed priority: PRIO_MODE=1, ports 0 and 2 requesting continuously -> port 2 never granted while port 0 requests.
- Reset mid-FILL: assert rsn_i=0 while mm_rd_req_o=1 -> all outputs 0 and ptr=0 asynchronously. After release, a new req_i=01 completes normally.
- Spurious ack: mm_data_rdy_i pulsed in IDLE and in RESP -> no state change and no extra rsp_valid_o.
